gfx_video_mode_sequencer: RTL and testbench

Owns the timing configuration of the programmable VGA sync generator and sequences video mode changes safely.
- Holds a built-in mode table and drives the generator's timing inputs (H/V totals, resolution, porches, sync sizes, polarities, clock divider).
- On a mode request: blanks video at a frame boundary, holds the generator in reset while loading new timing, releases it, waits for the new timing to stabilise, then acknowledges.
- Sits between the host/config logic and the sync generator.

---
 rtl/gfx_video_mode_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_gfx_video_mode_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_video_mode_sequencer.sv
// gfx_video_mode_sequencer: owns VGA sync generator timing and
// sequences mode changes (blank, hold reset, reload, settle, ack).
//
// Optional feature macro: GFX_MODE_SEQ_USER_MODE_EN
//   defined   -> mode 7 is a writable user mode (user_wr/addr/data)
//   undefined -> modes 4..7 invalid, no user ports
//
// Ports:
//   CLK_IN, reset         clock, sync active-high reset
//   mode_sel, mode_req    request interface (sampled when idle)
//   mode_busy/ack/err     sequence status and result pulses
//   mode_active           mode currently loaded
//   VS_in                 VS_out fed back from the sync generator
//   sync_reset, blank     generator reset and pixel blanking
//   CLK_DIVIDE_OUT        pixel clock divider
//   VID_*                 H/V timing registers to the generator
module gfx_video_mode_sequencer #(
  parameter int HC_BITS       = 16,
  parameter int VC_BITS       = 16,
  parameter int DEFAULT_MODE  = 0,
  parameter int RST_HOLD      = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int BLANK_TIMEOUT = 4000000
) (
  input  logic               CLK_IN,
  input  logic               reset,
  input  logic [2:0]         mode_sel,
  input  logic               mode_req,
`ifdef GFX_MODE_SEQ_USER_MODE_EN
  input  logic               user_wr,
  input  logic [3:0]         user_addr,
  input  logic [15:0]        user_data,
`endif
  output logic               mode_busy,
  output logic               mode_ack,
  output logic               mode_err,
  output logic [2:0]         mode_active,
  input  logic               VS_in,
  output logic               sync_reset,
  output logic               blank,
  output logic [2:0]         CLK_DIVIDE_OUT,
  output logic [HC_BITS-1:0] VID_h_total,
  output logic [HC_BITS-1:0] VID_h_res,
  output logic [HC_BITS-1:0] VID_hs_front_porch,
  output logic [HC_BITS-1:0] VID_hs_size,
  output logic               VID_hs_polarity,
  output logic [VC_BITS-1:0] VID_v_total,
  output logic [VC_BITS-1:0] VID_v_res,
  output logic [VC_BITS-1:0] VID_vs_front_porch,
  output logic [VC_BITS-1:0] VID_vs_size,
  output logic               VID_vs_polarity
);

  typedef enum logic [2:0] {
    RESET_LOAD,
    IDLE,
    BLANK,
    HOLD_RST,
    SETTLE,
    DONE
  } state_t;

  typedef struct packed {
    logic [HC_BITS-1:0] ht;
    logic [HC_BITS-1:0] hr;
    logic [HC_BITS-1:0] hfp;
    logic [HC_BITS-1:0] hs;
    logic               hp;
    logic [VC_BITS-1:0] vt;
    logic [VC_BITS-1:0] vr;
    logic [VC_BITS-1:0] vfp;
    logic [VC_BITS-1:0] vs;
    logic               vp;
    logic [2:0]         div;
  } tmg_t;

  localparam int TW =
    (BLANK_TIMEOUT > 1) ? $clog2(BLANK_TIMEOUT) : 1;
  localparam logic [2:0] DEF = 3'(DEFAULT_MODE);

  function automatic tmg_t mk(
    input int ht, input int hr,
    input int hfp, input int hs, input int hp,
    input int vt, input int vr,
    input int vfp, input int vs, input int vp,
    input int dv
  );
    tmg_t t;
    t.ht  = HC_BITS'(ht);
    t.hr  = HC_BITS'(hr);
    t.hfp = HC_BITS'(hfp);
    t.hs  = HC_BITS'(hs);
    t.hp  = 1'(hp);
    t.vt  = VC_BITS'(vt);
    t.vr  = VC_BITS'(vr);
    t.vfp = VC_BITS'(vfp);
    t.vs  = VC_BITS'(vs);
    t.vp  = 1'(vp);
    t.div = 3'(dv);
    return t;
  endfunction

  function automatic tmg_t rom(input logic [2:0] m);
    tmg_t t;
    case (m)
      3'd1: t = mk(1056, 800, 40, 128, 0,
                   628, 600, 1, 4, 0, 2);
      3'd2: t = mk(1650, 1280, 110, 40, 0,
                   750, 720, 5, 5, 0, 1);
      3'd3: t = mk(2200, 1920, 88, 44, 0,
                   1125, 1080, 4, 5, 0, 0);
      default: t = mk(800, 640, 16, 96, 1,
                      525, 480, 10, 2, 1, 3);
    endcase
    return t;
  endfunction

  function automatic logic valid_m(input logic [2:0] m);
`ifdef GFX_MODE_SEQ_USER_MODE_EN
    return (m <= 3'd3) || (m == 3'd7);
`else
    return m <= 3'd3;
`endif
  endfunction

  state_t       state;
  state_t       state_nx;
  logic [7:0]   hcnt;
  logic [3:0]   fcnt;
  logic [TW-1:0] tmo;
  logic         boot;
  logic         ack_q;
  logic         err_q;
  logic         vs_q;
  logic         vs_qq;
  logic [2:0]   act;
  logic [2:0]   tgt;
  tmg_t         cur;
  tmg_t         nxt_t;
  logic         vs_act;
  logic         vs_edge;
  logic         tmo_hit;
  logic         req;
  logic         same;
  logic         req_bad;
  logic         req_same;
  logic         req_go;
  logic         done_ack;
  logic         hold_entry;

`ifdef GFX_MODE_SEQ_USER_MODE_EN
  tmg_t usr;

  always_ff @(posedge CLK_IN) begin
    if (reset) begin
      usr <= rom(3'd0);
    end else if (user_wr) begin
      case (user_addr)
        4'd0:  usr.ht  <= HC_BITS'(user_data);
        4'd1:  usr.hr  <= HC_BITS'(user_data);
        4'd2:  usr.hfp <= HC_BITS'(user_data);
        4'd3:  usr.hs  <= HC_BITS'(user_data);
        4'd4:  usr.hp  <= user_data[0];
        4'd5:  usr.vt  <= VC_BITS'(user_data);
        4'd6:  usr.vr  <= VC_BITS'(user_data);
        4'd7:  usr.vfp <= VC_BITS'(user_data);
        4'd8:  usr.vs  <= VC_BITS'(user_data);
        4'd9:  usr.vp  <= user_data[0];
        4'd10: usr.div <= user_data[2:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt_t = rom(tgt);
    if (tgt == 3'd7) nxt_t = usr;
  end

  // re-requesting the user mode reapplies edited values
  assign same = (mode_sel == act) && (mode_sel != 3'd7);
`else
  assign nxt_t = rom(tgt);
  assign same  = (mode_sel == act);
`endif

  // active level is the inverse of the polarity bit
  assign vs_act  = ~cur.vp;
  assign vs_edge = (vs_q == vs_act) && (vs_qq != vs_act);
  assign tmo_hit = (tmo == TW'(BLANK_TIMEOUT - 1));

  assign req      = (state == IDLE) && mode_req;
  assign req_bad  = req && !valid_m(mode_sel);
  assign req_same = req && valid_m(mode_sel) && same;
  assign req_go   = req && valid_m(mode_sel) && !same;

  always_comb begin
    state_nx   = state;
    sync_reset = 1'b0;
    blank      = 1'b0;
    mode_busy  = 1'b1;
    done_ack   = 1'b0;
    unique case (state)
      RESET_LOAD: begin
        sync_reset = 1'b1;
        blank      = 1'b1;
        state_nx   = HOLD_RST;
      end
      IDLE: begin
        mode_busy = 1'b0;
        if (req_go) state_nx = BLANK;
      end
      BLANK: begin
        blank = 1'b1;
        if (vs_edge || tmo_hit) state_nx = HOLD_RST;
      end
      HOLD_RST: begin
        sync_reset = 1'b1;
        blank      = 1'b1;
        if (hcnt == '0) state_nx = SETTLE;
      end
      SETTLE: begin
        blank = 1'b1;
        if (vs_edge &&
            fcnt == 4'(SETTLE_FRAMES - 1))
          state_nx = DONE;
      end
      DONE: begin
        done_ack = ~boot;
        state_nx = IDLE;
      end
      default: state_nx = RESET_LOAD;
    endcase
  end

  assign hold_entry = (state_nx == HOLD_RST) &&
                      (state != HOLD_RST);

  always_ff @(posedge CLK_IN) begin
    if (reset) begin
      state <= RESET_LOAD;
      hcnt  <= '0;
      fcnt  <= '0;
      tmo   <= '0;
      boot  <= 1'b1;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      act   <= DEF;
      tgt   <= DEF;
      cur   <= rom(DEF);
    end else begin
      state <= state_nx;
      vs_q  <= VS_in;
      vs_qq <= vs_q;
      ack_q <= req_same;
      err_q <= req_bad;
      if (req_go) tgt <= mode_sel;
      if (state == BLANK) tmo <= tmo + TW'(1);
      else                tmo <= '0;
      if (hold_entry) begin
        cur  <= nxt_t;
        act  <= tgt;
        hcnt <= 8'(RST_HOLD - 1);
      end else if (hcnt != '0) begin
        hcnt <= hcnt - 8'd1;
      end
      if (state != SETTLE) fcnt <= '0;
      else if (vs_edge)    fcnt <= fcnt + 4'd1;
      if (state == DONE) boot <= 1'b0;
    end
  end

  assign mode_ack    = ack_q | done_ack;
  assign mode_err    = err_q;
  assign mode_active = act;

  assign CLK_DIVIDE_OUT     = cur.div;
  assign VID_h_total        = cur.ht;
  assign VID_h_res          = cur.hr;
  assign VID_hs_front_porch = cur.hfp;
  assign VID_hs_size        = cur.hs;
  assign VID_hs_polarity    = cur.hp;
  assign VID_v_total        = cur.vt;
  assign VID_v_res          = cur.vr;
  assign VID_vs_front_porch = cur.vfp;
  assign VID_vs_size        = cur.vs;
  assign VID_vs_polarity    = cur.vp;

endmodule

// File: tb/tb_gfx_video_mode_sequencer.sv
// tb_gfx_video_mode_sequencer: randomized mode-change bench with a
// transaction-level model of the mode table and sequence timing.
module tb_gfx_video_mode_sequencer;

  localparam int RH = 16;
  localparam int SF = 2;
  localparam int BT = 100;

  logic        CLK_IN = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  mode_sel = 3'd0;
  logic        mode_req = 1'b0;
  logic        mode_busy, mode_ack, mode_err;
  logic [2:0]  mode_active;
  logic        VS_in = 1'b1;
  logic        sync_reset, blank;
  logic [2:0]  CLK_DIVIDE_OUT;
  logic [15:0] VID_h_total, VID_h_res;
  logic [15:0] VID_hs_front_porch, VID_hs_size;
  logic        VID_hs_polarity;
  logic [15:0] VID_v_total, VID_v_res;
  logic [15:0] VID_vs_front_porch, VID_vs_size;
  logic        VID_vs_polarity;
`ifdef GFX_MODE_SEQ_USER_MODE_EN
  logic        user_wr = 1'b0;
  logic [3:0]  user_addr = 4'd0;
  logic [15:0] user_data = 16'd0;
`endif

  int total = 0;
  int bad   = 0;
  int cur_m = 0;
  int tbl [8][11];

  gfx_video_mode_sequencer #(
    .HC_BITS(16), .VC_BITS(16), .DEFAULT_MODE(0),
    .RST_HOLD(RH), .SETTLE_FRAMES(SF),
    .BLANK_TIMEOUT(BT)
  ) dut (
    .CLK_IN(CLK_IN),
    .reset(reset),
    .mode_sel(mode_sel),
    .mode_req(mode_req),
`ifdef GFX_MODE_SEQ_USER_MODE_EN
    .user_wr(user_wr),
    .user_addr(user_addr),
    .user_data(user_data),
`endif
    .mode_busy(mode_busy),
    .mode_ack(mode_ack),
    .mode_err(mode_err),
    .mode_active(mode_active),
    .VS_in(VS_in),
    .sync_reset(sync_reset),
    .blank(blank),
    .CLK_DIVIDE_OUT(CLK_DIVIDE_OUT),
    .VID_h_total(VID_h_total),
    .VID_h_res(VID_h_res),
    .VID_hs_front_porch(VID_hs_front_porch),
    .VID_hs_size(VID_hs_size),
    .VID_hs_polarity(VID_hs_polarity),
    .VID_v_total(VID_v_total),
    .VID_v_res(VID_v_res),
    .VID_vs_front_porch(VID_vs_front_porch),
    .VID_vs_size(VID_vs_size),
    .VID_vs_polarity(VID_vs_polarity)
  );

  always #5 CLK_IN = ~CLK_IN;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_IN);
    #1;
  endtask

  function automatic logic act_lvl(input int m);
    return (tbl[m][9] == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic chk_mode(input int m);
    chk("h_total", VID_h_total, tbl[m][0]);
    chk("h_res", VID_h_res, tbl[m][1]);
    chk("hfp", VID_hs_front_porch, tbl[m][2]);
    chk("hs", VID_hs_size, tbl[m][3]);
    chk("hpol", VID_hs_polarity, tbl[m][4]);
    chk("v_total", VID_v_total, tbl[m][5]);
    chk("v_res", VID_v_res, tbl[m][6]);
    chk("vfp", VID_vs_front_porch, tbl[m][7]);
    chk("vs", VID_vs_size, tbl[m][8]);
    chk("vpol", VID_vs_polarity, tbl[m][9]);
    chk("div", CLK_DIVIDE_OUT, tbl[m][10]);
    chk("active", mode_active, m);
  endtask

  // busy-phase cycles with stray requests that must be ignored
  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      mode_sel = 3'($urandom_range(0, 7));
      mode_req = ($urandom_range(0, 3) == 0);
      step();
      chk("busy_hold", mode_busy, 1);
      chk("blank_hold", blank, 1);
      chk("sync_lo", sync_reset, 0);
      chk("no_ack", mode_ack, 0);
      chk("no_err", mode_err, 0);
    end
    mode_req = 1'b0;
  endtask

  task automatic blank_phase(input int old, input bit to);
    int n;
    logic [15:0] last;
    chk("req_busy", mode_busy, 1);
    chk("req_blank", blank, 1);
    chk("req_sync", sync_reset, 0);
    if (to) begin
      n = 0;
      last = VID_h_total;
      while (sync_reset === 1'b0 && n < 1000) begin
        n++;
        last = VID_h_total;
        step();
      end
      chk("blank_timeout", n, BT);
      chk("pre_hold_ht", last, tbl[old][0]);
    end else begin
      noise($urandom_range(0, 30));
      VS_in = act_lvl(old);
      step();
      chk("edge_wait", sync_reset, 0);
      chk("pre_hold_ht", VID_h_total, tbl[old][0]);
      step();
      chk("edge_hold", sync_reset, 1);
    end
  endtask

  task automatic hold_phase(input int m);
    int n;
    n = 0;
    VS_in = ~act_lvl(m);
    chk("hold_mode", mode_active, m);
    chk("hold_ht", VID_h_total, tbl[m][0]);
    while (sync_reset === 1'b1 && n < 400) begin
      n++;
      step();
    end
    chk("rst_len", n, RH);
  endtask

  task automatic settle_phase(input int m, input bit exp_ack);
    for (int e = 0; e < SF; e++) begin
      noise($urandom_range(2, 8));
      VS_in = act_lvl(m);
      step();
      if (e < SF - 1) begin
        noise($urandom_range(1, 3));
        VS_in = ~act_lvl(m);
      end else begin
        chk("pre_done_ack", mode_ack, 0);
        chk("pre_done_blank", blank, 1);
        step();
        chk("done_ack", mode_ack, exp_ack);
        chk("done_err", mode_err, 0);
        chk("done_blank", blank, 0);
        chk("done_busy", mode_busy, 1);
        VS_in = ~act_lvl(m);
        step();
        chk("idle_ack", mode_ack, 0);
        chk("idle_busy", mode_busy, 0);
        chk("idle_blank", blank, 0);
      end
    end
  endtask

  task automatic do_req(input int m, input bit to);
    bit valid;
    bit rerun;
    valid = (m < 4);
    rerun = 1'b0;
`ifdef GFX_MODE_SEQ_USER_MODE_EN
    valid = valid || (m == 7);
    rerun = (m == 7) && (cur_m == 7);
`endif
    mode_sel = 3'(m);
    mode_req = 1'b1;
    step();
    mode_req = 1'b0;
    if (!valid) begin
      chk("err_pulse", mode_err, 1);
      chk("err_no_ack", mode_ack, 0);
      chk("err_busy", mode_busy, 0);
      chk("err_active", mode_active, cur_m);
      step();
      chk("err_end", mode_err, 0);
      chk("err_ht", VID_h_total, tbl[cur_m][0]);
    end else if (m == cur_m && !rerun) begin
      chk("same_ack", mode_ack, 1);
      chk("same_err", mode_err, 0);
      chk("same_busy", mode_busy, 0);
      chk("same_blank", blank, 0);
      chk("same_sync", sync_reset, 0);
      step();
      chk("same_end", mode_ack, 0);
      chk("same_blank2", blank, 0);
      chk("same_sync2", sync_reset, 0);
    end else begin
      blank_phase(cur_m, to);
      hold_phase(m);
      settle_phase(m, 1'b1);
      cur_m = m;
      chk_mode(m);
    end
  endtask

  task automatic boot_release();
    VS_in = ~act_lvl(0);
    reset = 1'b0;
    step();
    chk("boot_sync", sync_reset, 1);
    hold_phase(0);
    settle_phase(0, 1'b0);
    cur_m = 0;
    chk_mode(0);
  endtask

  initial begin
    tbl[0] = '{800, 640, 16, 96, 1, 525, 480, 10, 2, 1, 3};
    tbl[1] = '{1056, 800, 40, 128, 0, 628, 600, 1, 4, 0, 2};
    tbl[2] = '{1650, 1280, 110, 40, 0, 750, 720, 5, 5, 0, 1};
    tbl[3] = '{2200, 1920, 88, 44, 0, 1125, 1080, 4, 5, 0, 0};
    for (int r = 4; r < 8; r++) tbl[r] = tbl[0];

    reset = 1'b1;
    repeat (3) step();
    chk("rst_sync", sync_reset, 1);
    chk("rst_blank", blank, 1);
    chk("rst_busy", mode_busy, 1);
    chk("rst_ack", mode_ack, 0);
    chk("rst_err", mode_err, 0);
    chk_mode(0);

    boot_release();

    do_req(3, 1'b0);
    do_req(3, 1'b0);
    do_req(5, 1'b0);
    do_req(1, 1'b1);

    for (int i = 0; i < 24; i++)
      do_req($urandom_range(0, 7),
             $urandom_range(0, 4) == 0);

    // abort a change to mode 2 partway through SETTLE
    if (cur_m == 2) do_req(0, 1'b0);
    mode_sel = 3'd2;
    mode_req = 1'b1;
    step();
    mode_req = 1'b0;
    blank_phase(cur_m, 1'b0);
    hold_phase(2);
    noise(3);
    VS_in = act_lvl(2);
    step();
    step();
    VS_in = ~act_lvl(2);
    noise(2);
    reset = 1'b1;
    step();
    chk("abort_active", mode_active, 0);
    chk("abort_ht", VID_h_total, 800);
    chk("abort_div", CLK_DIVIDE_OUT, 3);
    chk("abort_ack", mode_ack, 0);
    chk("abort_sync", sync_reset, 1);
    chk("abort_blank", blank, 1);
    cur_m = 0;
    step();
    chk("abort_ack2", mode_ack, 0);
    boot_release();
    do_req(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
